q_table_update_v3: RTL and testbench

//  Per-node Q-table updater for EER-RL cluster routing. On a one-cycle en pulse it takes one received packet (f*) and

---
 rtl/q_table_update_v3_pkg.sv | 32 +++
 rtl/q_table_update_v3.sv | 207 ++++++++++++++++++++
 tb/tb_q_table_update_v3.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/q_table_update_v3_pkg.sv
// Shared constants, FSM encoding and record types for the EER-RL Q-table updater.
package q_table_update_v3_pkg;

  localparam int WORD_WIDTH    = 16;
  localparam int MAX_NEIGHBORS = 64;
  localparam int MAX_CH        = 32;

  localparam logic [2:0] PKT_INVALID = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN_NB = 3'd1,
    ST_WR_NB   = 3'd2,
    ST_SCAN_CH = 3'd3,
    ST_WR_CH   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // One neighbor-bank record, in bank field order.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] id;
    logic [WORD_WIDTH-1:0] hops;
    logic [WORD_WIDTH-1:0] cluster;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] qvalue;
  } nb_entry_t;

  function automatic logic pkt_valid(input logic [2:0] ptype);
    return (ptype != PKT_INVALID);
  endfunction

endpackage

// File: rtl/q_table_update_v3.sv
// Q-table updater: scans the neighbor bank for the packet source (overwrite or append),
// then the known-CH bank for the advertised CH (append if absent), then pulses done.
module q_table_update_v3
  import q_table_update_v3_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] fSourceHops,
  input  logic [WORD_WIDTH-1:0] fClusterID,
  input  logic [WORD_WIDTH-1:0] fEnergyLeft,
  input  logic [WORD_WIDTH-1:0] fQValue,
  input  logic [WORD_WIDTH-1:0] fKnownCH,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] mSourceID,
  input  logic [WORD_WIDTH-1:0] mSourceHops,
  input  logic [WORD_WIDTH-1:0] mClusterID,
  input  logic [WORD_WIDTH-1:0] mEnergyLeft,
  input  logic [WORD_WIDTH-1:0] mQValue,
  input  logic [WORD_WIDTH-1:0] mNeighborCount,
  input  logic [WORD_WIDTH-1:0] mKnownCH,
  input  logic [WORD_WIDTH-1:0] mKnownCHCount,
  output logic [WORD_WIDTH-1:0] nodeID,
  output logic [WORD_WIDTH-1:0] nodeHops,
  output logic [WORD_WIDTH-1:0] nodeClusterID,
  output logic [WORD_WIDTH-1:0] nodeEnergy,
  output logic [WORD_WIDTH-1:0] nodeQValue,
  output logic [WORD_WIDTH-1:0] neighborCount,
  output logic [WORD_WIDTH-1:0] knownCH,
  output logic [WORD_WIDTH-1:0] knownCHCount,
  output logic                  wr_en,
  output logic                  done
);

  localparam logic [WORD_WIDTH-1:0] NB_MAX_W = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] CH_MAX_W = WORD_WIDTH'(MAX_CH);
  localparam logic [WORD_WIDTH-1:0] ONE_W    = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] ZERO_W   = WORD_WIDTH'(0);

  state_t                r_state, w_state_nxt;
  nb_entry_t             r_f_nb, w_f_nb_nxt;
  logic [WORD_WIDTH-1:0] r_f_ch, w_f_ch_nxt;
  logic [WORD_WIDTH-1:0] r_nb_new, w_nb_new_nxt;
  logic [WORD_WIDTH-1:0] r_ch_new, w_ch_new_nxt;
  nb_entry_t             r_node, w_node_nxt;
  logic [WORD_WIDTH-1:0] r_nb_cnt, w_nb_cnt_nxt;
  logic [WORD_WIDTH-1:0] r_known_ch, w_known_ch_nxt;
  logic [WORD_WIDTH-1:0] r_ch_cnt, w_ch_cnt_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic                  r_done, w_done_nxt;

  nb_entry_t w_f_in;
  nb_entry_t w_m_in;
  logic      w_nb_end, w_nb_room, w_nb_hit;
  logic      w_ch_end, w_ch_room, w_ch_hit;

  assign w_f_in = {fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue};
  assign w_m_in = {mSourceID, mSourceHops, mClusterID, mEnergyLeft, mQValue};

  // The count outputs are the bank address while busy, so the scan index lives in them.
  // Both end tests also stop at the bank depth so a corrupt count cannot run the scan off the end.
  assign w_nb_end  = (r_nb_cnt >= mNeighborCount) || (r_nb_cnt >= NB_MAX_W);
  assign w_nb_room = (mNeighborCount < NB_MAX_W);
  assign w_nb_hit  = (mSourceID == r_f_nb.id);
  assign w_ch_end  = (r_ch_cnt >= mKnownCHCount) || (r_ch_cnt >= CH_MAX_W);
  assign w_ch_room = (mKnownCHCount < CH_MAX_W);
  assign w_ch_hit  = (mKnownCH == r_f_ch);

  // Next-state and next-output logic; outputs are registered on the transition into each state.
  always_comb begin
    w_state_nxt    = r_state;
    w_f_nb_nxt     = r_f_nb;
    w_f_ch_nxt     = r_f_ch;
    w_nb_new_nxt   = r_nb_new;
    w_ch_new_nxt   = r_ch_new;
    w_node_nxt     = r_node;
    w_nb_cnt_nxt   = r_nb_cnt;
    w_known_ch_nxt = r_known_ch;
    w_ch_cnt_nxt   = r_ch_cnt;
    w_wr_en_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_f_nb_nxt = w_f_in;
          w_f_ch_nxt = fKnownCH;
          if (pkt_valid(fPacketType)) begin
            w_state_nxt  = ST_SCAN_NB;
            w_nb_cnt_nxt = ZERO_W;
          end else begin
            w_state_nxt  = ST_DONE;
            w_done_nxt   = 1'b1;
            w_nb_cnt_nxt = mNeighborCount;
            w_ch_cnt_nxt = mKnownCHCount;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN_NB: begin
        if (w_nb_end) begin
          if (w_nb_room) begin
            w_state_nxt    = ST_WR_NB;
            w_nb_new_nxt   = mNeighborCount + ONE_W;
            w_wr_en_nxt    = 1'b1;
            w_node_nxt     = r_f_nb;
            w_known_ch_nxt = mKnownCH;
          end else begin
            w_state_nxt  = ST_SCAN_CH;
            w_nb_new_nxt = NB_MAX_W;
            w_ch_cnt_nxt = ZERO_W;
          end
        end else if (w_nb_hit) begin
          w_state_nxt    = ST_WR_NB;
          w_nb_new_nxt   = mNeighborCount;
          w_wr_en_nxt    = 1'b1;
          w_node_nxt     = r_f_nb;
          w_known_ch_nxt = mKnownCH;
        end else begin
          w_nb_cnt_nxt = r_nb_cnt + ONE_W;
        end
      end
      ST_WR_NB: begin
        w_state_nxt  = ST_SCAN_CH;
        w_ch_cnt_nxt = ZERO_W;
      end
      ST_SCAN_CH: begin
        if (w_ch_hit) begin
          w_state_nxt  = ST_DONE;
          w_done_nxt   = 1'b1;
          w_nb_cnt_nxt = r_nb_new;
          w_ch_cnt_nxt = mKnownCHCount;
        end else if (w_ch_end) begin
          if (w_ch_room) begin
            // The neighbor entry under the current address is written back unchanged.
            w_state_nxt    = ST_WR_CH;
            w_ch_new_nxt   = mKnownCHCount + ONE_W;
            w_wr_en_nxt    = 1'b1;
            w_known_ch_nxt = r_f_ch;
            w_node_nxt     = w_m_in;
          end else begin
            w_state_nxt  = ST_DONE;
            w_done_nxt   = 1'b1;
            w_nb_cnt_nxt = r_nb_new;
            w_ch_cnt_nxt = CH_MAX_W;
          end
        end else begin
          w_ch_cnt_nxt = r_ch_cnt + ONE_W;
        end
      end
      ST_WR_CH: begin
        w_state_nxt  = ST_DONE;
        w_done_nxt   = 1'b1;
        w_nb_cnt_nxt = r_nb_new;
        w_ch_cnt_nxt = r_ch_new;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched packet and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_IDLE;
      r_f_nb     <= '0;
      r_f_ch     <= ZERO_W;
      r_nb_new   <= ZERO_W;
      r_ch_new   <= ZERO_W;
      r_node     <= '0;
      r_nb_cnt   <= ZERO_W;
      r_known_ch <= ZERO_W;
      r_ch_cnt   <= ZERO_W;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_f_nb     <= w_f_nb_nxt;
      r_f_ch     <= w_f_ch_nxt;
      r_nb_new   <= w_nb_new_nxt;
      r_ch_new   <= w_ch_new_nxt;
      r_node     <= w_node_nxt;
      r_nb_cnt   <= w_nb_cnt_nxt;
      r_known_ch <= w_known_ch_nxt;
      r_ch_cnt   <= w_ch_cnt_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign nodeID        = r_node.id;
  assign nodeHops      = r_node.hops;
  assign nodeClusterID = r_node.cluster;
  assign nodeEnergy    = r_node.energy;
  assign nodeQValue    = r_node.qvalue;
  assign neighborCount = r_nb_cnt;
  assign knownCH       = r_known_ch;
  assign knownCHCount  = r_ch_cnt;
  assign wr_en         = r_wr_en;
  assign done          = r_done;

endmodule

// File: tb/tb_q_table_update_v3.sv
// Randomized bench for q_table_update_v3: banks are async-read arrays, results are
// checked against a list-based reference of the neighbor and known-CH tables.
module tb_q_table_update_v3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] fSourceID = 16'd0, fSourceHops = 16'd0, fClusterID = 16'd0;
  logic [15:0] fEnergyLeft = 16'd0, fQValue = 16'd0, fKnownCH = 16'd0;
  logic [2:0]  fPacketType = 3'b000;
  logic [15:0] mSourceID, mSourceHops, mClusterID, mEnergyLeft, mQValue, mKnownCH;
  logic [15:0] mNeighborCount, mKnownCHCount;
  logic [15:0] nodeID, nodeHops, nodeClusterID, nodeEnergy, nodeQValue;
  logic [15:0] neighborCount, knownCH, knownCHCount;
  logic        wr_en, done;

  // Bench-side memory banks
  logic [15:0] bk_id [64], bk_hops [64], bk_cid [64], bk_eng [64], bk_q [64];
  logic [15:0] bk_ch [32];
  logic [15:0] bank_nb_cnt = 16'd0, bank_ch_cnt = 16'd0;
  logic        bank_clr = 1'b1;

  // Reference tables
  logic [15:0] ref_id [64], ref_hops [64], ref_cid [64], ref_eng [64], ref_q [64];
  logic [15:0] ref_ch [32];
  int ref_cnt = 0, ref_ch_cnt = 0;

  int n_cmp = 0, n_err = 0;

  q_table_update_v3 dut (
    .clk(clk), .nrst(nrst), .en(en),
    .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fClusterID(fClusterID),
    .fEnergyLeft(fEnergyLeft), .fQValue(fQValue), .fKnownCH(fKnownCH), .fPacketType(fPacketType),
    .mSourceID(mSourceID), .mSourceHops(mSourceHops), .mClusterID(mClusterID),
    .mEnergyLeft(mEnergyLeft), .mQValue(mQValue), .mNeighborCount(mNeighborCount),
    .mKnownCH(mKnownCH), .mKnownCHCount(mKnownCHCount),
    .nodeID(nodeID), .nodeHops(nodeHops), .nodeClusterID(nodeClusterID),
    .nodeEnergy(nodeEnergy), .nodeQValue(nodeQValue), .neighborCount(neighborCount),
    .knownCH(knownCH), .knownCHCount(knownCHCount), .wr_en(wr_en), .done(done)
  );

  always #5 clk = ~clk;

  assign mSourceID      = bk_id[neighborCount[5:0]];
  assign mSourceHops    = bk_hops[neighborCount[5:0]];
  assign mClusterID     = bk_cid[neighborCount[5:0]];
  assign mEnergyLeft    = bk_eng[neighborCount[5:0]];
  assign mQValue        = bk_q[neighborCount[5:0]];
  assign mKnownCH       = bk_ch[knownCHCount[4:0]];
  assign mNeighborCount = bank_nb_cnt;
  assign mKnownCHCount  = bank_ch_cnt;

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 64; i++) begin
        bk_id[i] <= 16'd0; bk_hops[i] <= 16'd0; bk_cid[i] <= 16'd0;
        bk_eng[i] <= 16'd0; bk_q[i] <= 16'd0;
      end
      for (int i = 0; i < 32; i++) bk_ch[i] <= 16'd0;
    end else if (wr_en) begin
      bk_id[neighborCount[5:0]]   <= nodeID;
      bk_hops[neighborCount[5:0]] <= nodeHops;
      bk_cid[neighborCount[5:0]]  <= nodeClusterID;
      bk_eng[neighborCount[5:0]]  <= nodeEnergy;
      bk_q[neighborCount[5:0]]    <= nodeQValue;
      bk_ch[knownCHCount[4:0]]    <= knownCH;
    end
  end

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {nodeID, nodeHops, nodeClusterID, nodeEnergy, nodeQValue,
            neighborCount, knownCH, knownCHCount, wr_en, done};
  endfunction

  task automatic compare_tables();
    for (int i = 0; i < ref_cnt; i++)
      check_eq($sformatf("nb[%0d]", i), {bk_id[i], bk_hops[i], bk_cid[i], bk_eng[i], bk_q[i]},
               {ref_id[i], ref_hops[i], ref_cid[i], ref_eng[i], ref_q[i]});
    for (int i = 0; i < ref_ch_cnt; i++)
      check_eq($sformatf("ch[%0d]", i), bk_ch[i], ref_ch[i]);
  endtask

  task automatic run_txn(input logic [15:0] sid, input logic [15:0] hops, input logic [15:0] cid,
                         input logic [15:0] eng, input logic [15:0] qv, input logic [2:0] pt,
                         input logic [15:0] ch, input bit busy_en, input int rst_at);
    int h, j, exp_n, exp_wr, new_nb, new_ch, n_obs, wr_seen;
    bit got, aborted, nb_wr, ch_wr;
    h = -1; j = -1;
    for (int i = 0; i < ref_cnt; i++) if (h < 0 && ref_id[i] == sid) h = i;
    for (int i = 0; i < ref_ch_cnt; i++) if (j < 0 && ref_ch[i] == ch) j = i;
    if (pt == 3'b000) begin
      nb_wr = 1'b0; ch_wr = 1'b0; exp_n = 0;
      new_nb = ref_cnt; new_ch = ref_ch_cnt;
    end else begin
      nb_wr  = (h >= 0) || (ref_cnt < 64);
      ch_wr  = (j < 0) && (ref_ch_cnt < 32);
      exp_n  = ((h >= 0) ? h + 1 : ref_cnt + 1) + int'(nb_wr)
             + ((j >= 0) ? j + 1 : ref_ch_cnt + 1) + int'(ch_wr);
      new_nb = (h < 0 && ref_cnt < 64) ? ref_cnt + 1 : ref_cnt;
      new_ch = ch_wr ? ref_ch_cnt + 1 : ref_ch_cnt;
    end
    exp_wr = int'(nb_wr) + int'(ch_wr);

    @(negedge clk);
    fSourceID = sid; fSourceHops = hops; fClusterID = cid; fEnergyLeft = eng;
    fQValue = qv; fPacketType = pt; fKnownCH = ch; en = 1'b1;
    got = 1'b0; aborted = 1'b0; n_obs = -1; wr_seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 0) begin
        // Scramble inputs so only the latched copy can be used.
        en = 1'b0;
        fSourceID = 16'($urandom); fQValue = 16'($urandom); fKnownCH = 16'($urandom);
        fPacketType = 3'($urandom);
      end
      if (busy_en && c == 1) en = 1'b1;
      if (busy_en && c == 2) en = 1'b0;
      if (c == rst_at) begin
        nrst = 1'b0;
        #1;
        check_eq("rst_async_outs", all_outs(), 160'd0);
        @(negedge clk);
        nrst = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (wr_en) wr_seen++;
      if (done) begin got = 1'b1; n_obs = c; break; end
    end
    if (aborted) begin
      check_eq("abort_no_write", wr_seen, 0);
      compare_tables();
      return;
    end
    check_eq("done_seen", got, 1'b1);
    check_eq("latency", n_obs, exp_n);
    check_eq("wr_count", wr_seen, exp_wr);
    check_eq("nb_count", neighborCount, new_nb);
    check_eq("ch_count", knownCHCount, new_ch);

    if (pt != 3'b000) begin
      if (h >= 0) begin
        ref_hops[h] = hops; ref_cid[h] = cid; ref_eng[h] = eng; ref_q[h] = qv;
      end else if (ref_cnt < 64) begin
        ref_id[ref_cnt] = sid; ref_hops[ref_cnt] = hops; ref_cid[ref_cnt] = cid;
        ref_eng[ref_cnt] = eng; ref_q[ref_cnt] = qv;
        ref_cnt++;
      end
      if (ch_wr) begin
        ref_ch[ref_ch_cnt] = ch;
        ref_ch_cnt++;
      end
    end

    @(negedge clk);
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("idle_hold_count", {neighborCount, knownCHCount}, {16'(new_nb), 16'(new_ch)});
    bank_nb_cnt = 16'(ref_cnt);
    bank_ch_cnt = 16'(ref_ch_cnt);
    compare_tables();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nid;
    repeat (3) @(negedge clk);
    bank_clr = 1'b0;
    check_eq("reset_outs", all_outs(), 160'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Directed sequence from empty tables
    run_txn(16'd1,  16'd2, 16'd2, 16'h8000, 16'h3000, 3'b101, 16'd15, 1'b0, -1);
    run_txn(16'd17, 16'd3, 16'd2, 16'h1800, 16'hB800, 3'b101, 16'd15, 1'b1, -1);
    run_txn(16'd1,  16'd2, 16'd2, 16'h8000, 16'h4000, 3'b011, 16'd15, 1'b0, -1);
    run_txn(16'd40, 16'd1, 16'd1, 16'h1111, 16'h2222, 3'b000, 16'd9,  1'b0, -1);
    // Reset while scanning the neighbor bank, then a normal transaction
    run_txn(16'd55, 16'd4, 16'd3, 16'h0101, 16'h0202, 3'b001, 16'd21, 1'b0, 1);
    run_txn(16'd55, 16'd4, 16'd3, 16'h0101, 16'h0202, 3'b001, 16'd21, 1'b0, -1);

    // Random traffic with repeated IDs so hits and misses mix
    for (int t = 0; t < 60; t++)
      run_txn(16'($urandom_range(1, 80)), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 3'($urandom_range(0, 7)), 16'($urandom_range(1, 40)),
              1'($urandom_range(0, 1)), -1);

    // Fill the neighbor table, then push a new ID and an existing ID at full
    nid = 1000;
    while (ref_cnt < 64) begin
      run_txn(16'(nid), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              3'b001, 16'($urandom_range(1, 40)), 1'b0, -1);
      nid++;
    end
    run_txn(16'd999, 16'd7, 16'd7, 16'h7777, 16'h7777, 3'b110, 16'd15, 1'b1, -1);
    run_txn(ref_id[63], 16'd8, 16'd8, 16'h8888, 16'h8888, 3'b010, 16'd15, 1'b0, -1);

    // Fill the known-CH table, then advertise one more unknown CH
    nid = 500;
    while (ref_ch_cnt < 32) begin
      run_txn(16'($urandom_range(1, 80)), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 3'b100, 16'(nid), 1'b0, -1);
      nid++;
    end
    run_txn(16'd1234, 16'd5, 16'd5, 16'h5555, 16'h5555, 3'b111, 16'd4000, 1'b0, -1);

    for (int t = 0; t < 20; t++)
      run_txn(16'($urandom_range(1, 1100)), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 3'($urandom_range(0, 7)), 16'($urandom_range(1, 600)),
              1'($urandom_range(0, 1)), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
